// File: rtl/sifa_pkg.sv
// Shared types, default parameters and helpers for the SIFA fault-reaction harness.
package sifa_pkg;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int DEF_SHARES  = 2;
    localparam int DEF_LATENCY = 2;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_THRESH  = 4;

    // Widest flag vector all_equal accepts; unused upper bits must be padded with ones.
    localparam int MAX_SHARES  = 32;

    function automatic logic all_equal(input logic [MAX_SHARES-1:0] det);
        return &det;
    endfunction

endpackage

// File: rtl/sifa_valid_pipe.sv
// LATENCY-deep 1-bit issue tracker; tail marks the cycle whose multiplier outputs belong to an issue.
module sifa_valid_pipe #(
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic tail
);

    logic [LATENCY-1:0] shift_r;

    // Shift the issue marker one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r <= '0;
        end else begin
            shift_r[0] <= din;
            for (int i = 1; i < LATENCY; i++) begin
                shift_r[i] <= shift_r[i-1];
            end
        end
    end

    assign tail = shift_r[LATENCY-1];

endmodule

// File: rtl/sifa_fault_response.sv
// Releases copy-0 result shares only when all duplicated-copy equality flags agree;
// counts detected faults and locks all output once the count reaches THRESH.
module sifa_fault_response
    import sifa_pkg::*;
#(
    parameter int SHARES  = DEF_SHARES,
    parameter int LATENCY = DEF_LATENCY,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int THRESH  = DEF_THRESH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              port_issue,
    input  logic [SHARES-1:0] port_det_in,
    input  logic [SHARES-1:0] port_res_in,
    input  logic              port_clear,
    output logic              port_out_valid,
    output logic [SHARES-1:0] port_out,
    output logic              port_alarm,
    output logic              port_locked,
    output logic [CNT_W-1:0]  port_fault_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    slot_v_s;
    logic [MAX_SHARES-1:0]   det_pad_s;
    logic                    ok_s;
    logic                    fault_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_base_s;
    logic [CNT_W-1:0]        cnt_inc_s;
    logic [CNT_W-1:0]        cnt_nxt_s;
    logic                    alarm_r;
    logic                    alarm_base_s;
    logic                    alarm_nxt_s;
    logic                    out_valid_r;
    logic                    out_valid_nxt_s;
    logic [SHARES-1:0]       out_r;
    logic [SHARES-1:0]       out_nxt_s;

    sifa_valid_pipe #(
        .LATENCY (LATENCY)
    ) u_valid_pipe (
        .clk   (clk),
        .reset (reset),
        .din   (port_issue),
        .tail  (slot_v_s)
    );

    // Agreement check and fault detection; clear is applied before a same-cycle fault counts.
    always_comb begin
        det_pad_s                = '1;
        det_pad_s[SHARES-1:0]    = port_det_in;
        ok_s                     = all_equal(det_pad_s);
        fault_s                  = slot_v_s & ~ok_s;
        cnt_base_s               = port_clear ? '0 : cnt_r;
        alarm_base_s             = port_clear ? 1'b0 : alarm_r;
        if (cnt_base_s == CNT_MAX) begin
            cnt_inc_s = cnt_base_s;
        end else begin
            cnt_inc_s = cnt_base_s + CNT_W'(1);
        end
    end

    // Next-state logic: lock on the fault that brings the count to THRESH.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN: begin
                if (fault_s && (cnt_inc_s >= THRESH_C)) begin
                    state_nxt_s = LOCKED;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            LOCKED: begin
                if (port_clear) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: state_nxt_s = RUN;
        endcase
    end

    // Output decode: release or suppress the slot, based on the state at the sampling cycle.
    always_comb begin
        out_valid_nxt_s = 1'b0;
        out_nxt_s       = '0;
        cnt_nxt_s       = cnt_base_s;
        alarm_nxt_s     = alarm_base_s;
        case (state_r)
            RUN: begin
                if (slot_v_s && ok_s) begin
                    out_valid_nxt_s = 1'b1;
                    out_nxt_s       = port_res_in;
                end else if (fault_s) begin
                    cnt_nxt_s       = cnt_inc_s;
                    alarm_nxt_s     = 1'b1;
                end else begin
                    out_valid_nxt_s = 1'b0;
                end
            end
            LOCKED: begin
                out_valid_nxt_s = 1'b0;
                out_nxt_s       = '0;
            end
            default: begin
                out_valid_nxt_s = 1'b0;
                out_nxt_s       = '0;
            end
        endcase
    end

    // State, counter, alarm and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= RUN;
            cnt_r       <= '0;
            alarm_r     <= 1'b0;
            out_valid_r <= 1'b0;
            out_r       <= '0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            alarm_r     <= alarm_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_r       <= out_nxt_s;
        end
    end

    assign port_out_valid = out_valid_r;
    assign port_out       = out_r;
    assign port_alarm     = alarm_r;
    assign port_locked    = (state_r == LOCKED);
    assign port_fault_cnt = cnt_r;

endmodule
